// File: rtl/jt51_pg_keyseq.sv
// jt51_pg_keyseq: slot sequencer and key-on scheduler for the phase generator.
//
// A free-running 5-bit slot counter ({op[1:0], ch[2:0]}) steps the phase
// generator pipeline. Channel key-on writes arrive through a valid/ready
// handshake. Each accepted write is then held off for one full frame so that
// every slot is visited once while the new key state is applied. An
// off-to-on transition of a slot's key produces a one-cycle phase reset. That
// pulse is delayed so that it lines up with phase-generator stage III.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   kon_valid  key-on write request
//   kon_ch     channel 0..7
//   kon_mask   new key state, bit i = operator i of the channel
//   kon_ready  request accepted when kon_valid & kon_ready
//   slot_I     slot presented to phase-generator stage I
//   zero       high while slot_I == 0
//   kon_I      key state of slot_I, including this cycle's update
//   pg_rst_III phase reset for the slot seen at slot_I RST_DLY cycles ago
//   busy       high while an accepted write is being applied
module jt51_pg_keyseq #(
  parameter int RST_DLY = 2,
  parameter int FRAME   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kon_valid,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_mask,
  output logic       kon_ready,
  output logic [4:0] slot_I,
  output logic       zero,
  output logic       kon_I,
  output logic       pg_rst_III,
  output logic       busy
);

  localparam logic [4:0] FC_INIT = 5'(FRAME - 1);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t               state, state_nxt;
  logic [4:0]           fc, fc_nxt;
  logic                 take;
  logic [31:0]          cur_key, next_key;
  logic [RST_DLY-1:0]   rst_pipe;
  logic                 rise;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fc    <= '0;
    end else begin
      state <= state_nxt;
      fc    <= fc_nxt;
    end
  end

  // FSM next state and handshake outputs. APPLY lasts exactly one frame
  // (fc counts 31 down to 0), so every slot sees the new key state once
  // before another write can be taken.
  always_comb begin
    state_nxt = state;
    fc_nxt    = fc;
    kon_ready = 1'b0;
    busy      = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        kon_ready = 1'b1;
        if (kon_valid) begin
          take      = 1'b1;
          fc_nxt    = FC_INIT;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        busy   = 1'b1;
        fc_nxt = fc - 5'd1;
        if (fc == 5'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The slot update reads next_key before this cycle's write lands. A write
  // to the slot currently shown is therefore picked up on its next visit.
  assign rise  = next_key[slot_I] & ~cur_key[slot_I];
  assign kon_I = next_key[slot_I];

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_I   <= '0;
      zero     <= 1'b1;
      cur_key  <= '0;
      next_key <= '0;
      rst_pipe <= '0;
    end else begin
      slot_I           <= slot_I + 5'd1;
      zero             <= (slot_I == 5'd31);
      cur_key[slot_I]  <= next_key[slot_I];
      rst_pipe[0]      <= rise;
      for (int i = 1; i < RST_DLY; i++) rst_pipe[i] <= rst_pipe[i-1];
      if (take) begin
        for (int i = 0; i < 4; i++) next_key[{i[1:0], kon_ch}] <= kon_mask[i];
      end
    end
  end

  assign pg_rst_III = rst_pipe[RST_DLY-1];

endmodule

// File: tb/tb_jt51_pg_keyseq.sv
// Bench for jt51_pg_keyseq. A cycle-indexed reference model predicts the
// outputs. The model keeps the requested and applied key per slot. It holds
// expected pulse times as absolute cycle numbers and the next acceptance
// time as arithmetic on the cycle count.
module tb_jt51_pg_keyseq;
  localparam int RST_DLY = 2;
  localparam int FRAME   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kon_valid = 1'b0;
  logic [2:0] kon_ch = '0;
  logic [3:0] kon_mask = '0;
  logic       kon_ready, zero, kon_I, pg_rst_III, busy;
  logic [4:0] slot_I;

  jt51_pg_keyseq #(.RST_DLY(RST_DLY), .FRAME(FRAME)) dut (
    .clk(clk), .rst(rst), .kon_valid(kon_valid), .kon_ch(kon_ch),
    .kon_mask(kon_mask), .kon_ready(kon_ready), .slot_I(slot_I),
    .zero(zero), .kon_I(kon_I), .pg_rst_III(pg_rst_III), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  bit        armed = 0;
  int        t = 0;
  int        ready_at = 0;
  bit [31:0] want = '0;
  bit [31:0] have = '0;
  int        pend_q[$];
  // observation helpers
  int        pulses = 0;
  int        first_pulse_t = -1;
  int        xfers[$];
  int        t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] s;
    bit         exp_pg;
    @(negedge clk);
    if (armed) begin
      s      = 5'(t % FRAME);
      exp_pg = (pend_q.size() > 0) && (pend_q[0] == t);
      chk("slot_I", 32'(slot_I), 32'(s));
      chk("zero", 32'(zero), 32'(s == 5'd0));
      chk("kon_I", 32'(kon_I), 32'(want[s]));
      chk("pg_rst_III", 32'(pg_rst_III), 32'(exp_pg));
      chk("kon_ready", 32'(kon_ready), 32'(t >= ready_at));
      chk("busy", 32'(busy), 32'(t < ready_at));
      if (exp_pg) void'(pend_q.pop_front());
    end
    if (pg_rst_III === 1'b1) begin
      pulses++;
      if (first_pulse_t < 0) first_pulse_t = t;
    end
    if (!rst && kon_valid && kon_ready === 1'b1) xfers.push_back(t);
    // model advance across the coming edge
    if (rst) begin
      armed = 1; t = 0; ready_at = 0; want = '0; have = '0; pend_q.delete();
    end else if (armed) begin
      s = 5'(t % FRAME);
      if (want[s] && !have[s]) pend_q.push_back(t + RST_DLY);
      have[s] = want[s];
      if (kon_valid && t >= ready_at) begin
        for (int i = 0; i < 4; i++) want[{i[1:0], kon_ch}] = kon_mask[i];
        ready_at = t + FRAME + 1;
      end
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && t < ready_at; k++) tick();
  endtask

  task automatic wait_slot(input int v);
    for (int k = 0; k < FRAME && (t % FRAME) != v; k++) tick();
  endtask

  task automatic send(input logic [2:0] ch, input logic [3:0] m);
    kon_valid = 1'b1; kon_ch = ch; kon_mask = m;
    tick();
    kon_valid = 1'b0;
  endtask

  initial begin
    // reset for three cycles, then a couple of idle frames
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    pulses = 0;
    idle(70);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // ch3 ops 0 and 2 on, written while slot 5 is shown -> slots 3 and 19
    wait_ready(); wait_slot(5);
    pulses = 0;
    send(3'd3, 4'b0101);
    idle(34);
    chk("pulses_0101", 32'(pulses), 32'd2);

    // add op 1 -> only slot 11 pulses
    wait_ready();
    pulses = 0;
    send(3'd3, 4'b0111);
    idle(36);
    chk("pulses_0111", 32'(pulses), 32'd1);

    // all off -> no pulses
    wait_ready();
    pulses = 0;
    send(3'd3, 4'b0000);
    idle(36);
    chk("pulses_0000", 32'(pulses), 32'd0);

    // back-to-back requests with valid held high
    wait_ready();
    xfers.delete();
    kon_valid = 1'b1; kon_ch = 3'd1; kon_mask = 4'b0011;
    for (int k = 0; k < 80 && xfers.size() < 2; k++) tick();
    kon_valid = 1'b0;
    chk("xfer_cnt", 32'(xfers.size()), 32'd2);
    if (xfers.size() >= 2) chk("xfer_gap", 32'(xfers[1] - xfers[0]), 32'd33);
    idle(4);

    // write ch0 op0 while slot 0 is shown -> pulse one frame later
    wait_ready(); wait_slot(0);
    t0 = t;
    first_pulse_t = -1;
    send(3'd0, 4'b0001);
    idle(40);
    chk("collide_dt", 32'(first_pulse_t - t0), 32'd34);

    // randomized writes
    for (int n = 0; n < 12; n++) begin
      idle($urandom_range(0, 40));
      wait_ready();
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    idle(40);

    // reset in the middle of an apply
    wait_ready();
    send(3'd7, 4'b1111);
    idle(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    idle(40);
    chk("post_rst_pulses", 32'(pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
